// File: rtl/seg7_display_writer.sv
// Writes a 16-bit value as four digits to a 7-segment controller, one digit per cycle.
// Define SEG7_BCD_EN to show decimal (shift-and-add-3 conversion, saturating at 9999).
module seg7_display_writer (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [15:0] wr_data,
  output logic        busy,
  output logic        done,
  output logic        ovf,
  output logic        seg7_sel,
  output logic [1:0]  addr,
  output logic [3:0]  data_to_wr
);

  // state | meaning
  // IDLE  | waiting for wr_en; done pulses here for one cycle after a request
  // CONV  | binary-to-BCD, one shift-and-add-3 iteration per cycle (BCD build only)
  // WRITE | four strobed digit writes, addr 0..3
`ifdef SEG7_BCD_EN
  typedef enum logic [1:0] {IDLE, CONV, WRITE} state_t;
`else
  typedef enum logic [1:0] {IDLE, WRITE} state_t;
`endif

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [15:0] digits, digits_nxt;
  logic        busy_nxt, done_nxt, sel_nxt;
  logic [1:0]  addr_nxt;
  logic [3:0]  data_nxt;

`ifdef SEG7_BCD_EN
  logic [15:0] bin, bin_nxt;
  logic [15:0] bcd_adj, bcd_step;
  logic        sat, sat_nxt;
  logic        ovf_q, ovf_nxt;

  // digits doubles as the BCD accumulator while converting
  always_comb begin
    bcd_adj = digits;
    for (int i = 0; i < 4; i++) begin
      if (digits[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = digits[4*i +: 4] + 4'd3;
    end
    bcd_step = {bcd_adj[14:0], bin[15]};
  end
`endif

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    digits_nxt = digits;
    done_nxt   = 1'b0;
`ifdef SEG7_BCD_EN
    bin_nxt    = bin;
    sat_nxt    = sat;
    ovf_nxt    = ovf_q;
`endif
    case (state)
      IDLE: begin
        if (wr_en) begin
          cnt_nxt = 4'd0;
`ifdef SEG7_BCD_EN
          bin_nxt    = wr_data;
          sat_nxt    = (wr_data > 16'd9999);
          ovf_nxt    = 1'b0;
          digits_nxt = 16'h0000;
          state_nxt  = CONV;
`else
          digits_nxt = wr_data;
          state_nxt  = WRITE;
`endif
        end
      end
`ifdef SEG7_BCD_EN
      CONV: begin
        digits_nxt = bcd_step;
        bin_nxt    = {bin[14:0], 1'b0};
        cnt_nxt    = cnt + 4'd1;
        if (cnt == 4'd15) begin
          state_nxt = WRITE;
          cnt_nxt   = 4'd0;
          if (sat) begin
            digits_nxt = 16'h9999;
            ovf_nxt    = 1'b1;
          end
        end
      end
`endif
      WRITE: begin
        cnt_nxt = cnt + 4'd1;
        if (cnt == 4'd3) begin
          state_nxt = IDLE;
          cnt_nxt   = 4'd0;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // outputs are registered from the next-state view so they align with the state
    busy_nxt = (state_nxt != IDLE);
    sel_nxt  = (state_nxt == WRITE);
    addr_nxt = sel_nxt ? cnt_nxt[1:0] : 2'd0;
    data_nxt = sel_nxt ? digits_nxt[{cnt_nxt[1:0], 2'b00} +: 4] : 4'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      digits     <= 16'h0000;
      busy       <= 1'b0;
      done       <= 1'b0;
      seg7_sel   <= 1'b0;
      addr       <= 2'd0;
      data_to_wr <= 4'd0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      digits     <= digits_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      seg7_sel   <= sel_nxt;
      addr       <= addr_nxt;
      data_to_wr <= data_nxt;
    end
  end

`ifdef SEG7_BCD_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      bin   <= 16'h0000;
      sat   <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      bin   <= bin_nxt;
      sat   <= sat_nxt;
      ovf_q <= ovf_nxt;
    end
  end
  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: doc/seg7_display_writer.md
SEG7_DISPLAY_WRITER -- requirements
Module: seg7_display_writer

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed as listed below.
REQ-002 clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 wr_en  input  1  single-cycle request to display wr_data.
REQ-005 wr_data  input  16  value to display.
REQ-006 busy  output  1  high while a request is being converted or written.
REQ-007 done  output  1  one-cycle pulse when all four digits have been written.
REQ-008 ovf  output  1  high when the last accepted value exceeded the display range; held until the next acceptance.
REQ-009 seg7_sel  output  1  write strobe to the downstream 7-segment controller.
REQ-010 addr  output  2  digit index to the controller (0 = rightmost, least significant).
REQ-011 data_to_wr  output  4  digit nibble to the controller.

Function
REQ-012 The block SHALL implement the states IDLE, CONV and WRITE, and SHALL register all outputs.
REQ-013 In IDLE, wr_en=1 SHALL latch wr_data and clear ovf; the next state SHALL be CONV when SEG7_BCD_EN is defined, otherwise WRITE.
REQ-014 CONV SHALL perform 16-iteration shift-and-add-3 binary-to-BCD conversion, one iteration per cycle, then move to WRITE.
REQ-015 If the latched value exceeds 9999 in BCD mode, all four digits SHALL be forced to 9 and ovf SHALL be set.
REQ-016 WRITE SHALL last exactly 4 cycles; in cycle k (k=0..3) it SHALL drive seg7_sel=1, addr=k and data_to_wr=digit k.
REQ-017 After WRITE cycle 3, the state SHALL return to IDLE, and done SHALL be 1 for exactly the first IDLE cycle.
REQ-018 seg7_sel SHALL be 0 outside WRITE; addr and data_to_wr SHALL be 0 whenever seg7_sel=0.
REQ-019 busy SHALL be 1 in CONV and WRITE and 0 in IDLE, including the done cycle.
REQ-020 wr_en while busy=1 SHALL be ignored, with no queuing and no effect on the latched value.
REQ-021 wr_en in the done cycle SHALL be accepted like any other IDLE cycle.
REQ-022 Latency from the accepting edge to the first seg7_sel cycle SHALL be 1 cycle without BCD and 17 cycles with BCD; done SHALL follow 4 cycles after the first seg7_sel cycle.
REQ-023 The hex-mode digit mapping SHALL be digit k = wr_data[4k+3:4k].

Reset
REQ-024 rst=1 SHALL force state IDLE and set busy, done, ovf, seg7_sel, addr, data_to_wr and all internal digit and iteration registers to 0.
REQ-025 rst asserted mid-CONV or mid-WRITE SHALL abort the operation: no further seg7_sel cycles and no done pulse for that request.
REQ-026 rst SHALL take priority over wr_en on the same edge.

Configuration
REQ-027 With macro SEG7_BCD_EN defined, the block SHALL display decimal via CONV, with saturation at 9999 and ovf as specified.
REQ-028 With SEG7_BCD_EN undefined, the CONV state and converter logic SHALL be absent, digits SHALL be raw hex nibbles, and ovf SHALL be constant 0.

Verification
REQ-029 Hex mode: wr_en with wr_data=0x1234 -> seg7_sel for 4 cycles with (addr,data) = (0,4),(1,3),(2,2),(3,1); done one cycle later; ovf=0.
REQ-030 BCD mode: wr_data=0x04D2 (1234) -> busy for 20 cycles; writes (0,4),(1,3),(2,2),(3,1) starting 17 cycles after acceptance; done in cycle 21.
REQ-031 BCD mode: wr_data=12345 -> writes 9,9,9,9 and ovf=1; a following request with wr_data=7 -> digits 7,0,0,0 and ovf=0.
REQ-032 A second wr_en with 0xFFFF during busy -> ignored; only the first value's digits are written and exactly one done pulse occurs.
REQ-033 rst during WRITE cycle 1 -> seg7_sel=0, busy=0 and all outputs 0 from the next cycle; no done pulse.
REQ-034 Hex mode: wr_en with 0xABCD asserted in the done cycle of a previous request -> accepted, and writes (0,D),(1,C),(2,B),(3,A) begin in the next cycle.
